// File: rtl/decoder_scan_if.sv
// rtl/decoder_scan_if.sv - control/status bundle between a line sequencer's controller and decoder_scan.
interface decoder_scan_if #(
  parameter int N = 2
);
  logic               e;
  logic [1:0]         mode;
  logic [N-1:0]       sel;
  logic               start;
  logic [(1<<N)-1:0]  y;
  logic [N-1:0]       idx;
  logic               busy;
  logic               done;

  modport master (output e, mode, sel, start, input y, idx, busy, done);
  modport slave  (input e, mode, sel, start, output y, idx, busy, done);
endinterface

// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - registered N-to-2^N one-hot decoder with direct, scan-up/down and one-shot sweep modes.
module decoder_scan #(
  parameter int N          = 2,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic          clk,
  input  logic          rst,
  decoder_scan_if.slave bus
);
  localparam int             W          = 1 << N;
  localparam int             DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL - 1);
  localparam logic [W-1:0]   INACT      = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [W-1:0]   ONE        = W'(1);
  localparam logic [N-1:0]   IDX_MAX    = '1;
  localparam logic [1:0]     M_DIRECT   = 2'b00;
  localparam logic [1:0]     M_UP       = 2'b01;
  localparam logic [1:0]     M_DOWN     = 2'b10;

  typedef enum logic {SW_IDLE, SW_RUN} sw_state_e;

  sw_state_e       state_q, state_d;
  logic [W-1:0]    y_q, y_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [1:0]      mode_q, mode_d;
  logic            done_q, done_d;
  logic            mode_chg;
  logic            dwell_last;

  assign mode_chg   = (bus.mode != mode_q);
  assign dwell_last = (dwell_q == DWELL_LAST);

  // With e low everything holds except y (inactive) and done (cleared).
  always_comb begin
    state_d = state_q;
    y_d     = INACT;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (bus.e) begin
      mode_d = bus.mode;
      case (bus.mode)
        M_DIRECT: begin
          state_d = SW_IDLE;
          idx_d   = bus.sel;
          dwell_d = '0;
          y_d     = (ONE << bus.sel) ^ INACT;
        end
        M_UP, M_DOWN: begin
          state_d = SW_IDLE;
          if (mode_chg) begin
            idx_d   = bus.sel;
            dwell_d = '0;
          end else if (dwell_last) begin
            dwell_d = '0;
            idx_d   = (bus.mode == M_UP) ? idx_q + 1'b1 : idx_q - 1'b1;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
          y_d = (ONE << idx_d) ^ INACT;
        end
        default: begin
          // Sweep: start is only honoured while idle; a run ends after the top line's dwell.
          if (state_q == SW_IDLE || mode_chg) begin
            state_d = SW_IDLE;
            if (mode_chg) dwell_d = '0;
            if (bus.start) begin
              state_d = SW_RUN;
              idx_d   = '0;
              dwell_d = '0;
              y_d     = ONE ^ INACT;
            end
          end else if (!dwell_last) begin
            dwell_d = dwell_q + 1'b1;
            y_d     = (ONE << idx_q) ^ INACT;
          end else begin
            dwell_d = '0;
            if (idx_q == IDX_MAX) begin
              state_d = SW_IDLE;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
              y_d   = (ONE << idx_d) ^ INACT;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SW_IDLE;
      y_q     <= INACT;
      idx_q   <= '0;
      dwell_q <= '0;
      mode_q  <= M_DIRECT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.idx  = idx_q;
  assign bus.busy = (state_q == SW_RUN);
  assign bus.done = done_q;
endmodule

// File: tb/tb_decoder_scan.sv
// tb/tb_decoder_scan.sv - vector table and scoreboard bench for decoder_scan in three configurations.
module tb_decoder_scan;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // a: N=2 DWELL=3; b: N=2 DWELL=2 (sweep); c: N=3 DWELL=4 active-low
  decoder_scan_if #(.N(2)) if_a ();
  decoder_scan_if #(.N(2)) if_b ();
  decoder_scan_if #(.N(3)) if_c ();

  decoder_scan #(.N(2), .DWELL(3), .ACTIVE_LOW(0)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  decoder_scan #(.N(2), .DWELL(2), .ACTIVE_LOW(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  decoder_scan #(.N(3), .DWELL(4), .ACTIVE_LOW(1)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  typedef struct {
    int         dut;
    logic       rst;
    logic       e;
    logic [1:0] mode;
    logic [2:0] sel;
    logic       start;
    logic [7:0] y;
    logic [2:0] idx;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t  tbl[$];
  vec_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic vec_t mk(int d, int r, int e, int m, int s, int st,
                              int y, int i, int b, int dn);
    vec_t v;
    v.dut = d;        v.rst = 1'(r);   v.e = 1'(e);      v.mode = 2'(m);
    v.sel = 3'(s);    v.start = 1'(st); v.y = 8'(y);     v.idx = 3'(i);
    v.busy = 1'(b);   v.done = 1'(dn);
    return v;
  endfunction

  function automatic int oh(int i);
    return 1 << i;
  endfunction

  function automatic int ohl(int i);
    return 255 ^ (1 << i);
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst;
    case (v.dut)
      0: begin if_a.e = v.e; if_a.mode = v.mode; if_a.sel = v.sel[1:0]; if_a.start = v.start; end
      1: begin if_b.e = v.e; if_b.mode = v.mode; if_b.sel = v.sel[1:0]; if_b.start = v.start; end
      default: begin if_c.e = v.e; if_c.mode = v.mode; if_c.sel = v.sel; if_c.start = v.start; end
    endcase
  endtask

  task automatic cmp(input string nm, input string fld, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s.%s got %0h expected %0h", nm, fld, got, want);
    end
  endtask

  task automatic check_out();
    vec_t       v;
    string      nm;
    logic [7:0] gy;
    logic [2:0] gi;
    logic       gb, gd;
    v  = exp_q.pop_front();
    nm = name_q.pop_front();
    case (v.dut)
      0: begin gy = {4'b0, if_a.y}; gi = {1'b0, if_a.idx}; gb = if_a.busy; gd = if_a.done; end
      1: begin gy = {4'b0, if_b.y}; gi = {1'b0, if_b.idx}; gb = if_b.busy; gd = if_b.done; end
      default: begin gy = if_c.y; gi = if_c.idx; gb = if_c.busy; gd = if_c.done; end
    endcase
    cmp(nm, "y", int'(gy), int'(v.y));
    cmp(nm, "idx", int'(gi), int'(v.idx));
    cmp(nm, "busy", int'(gb), int'(v.busy));
    cmp(nm, "done", int'(gd), int'(v.done));
  endtask

  task automatic apply(input vec_t v, input string nm);
    drive(v);
    exp_q.push_back(v);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int up_seq[9]   = '{2, 2, 3, 3, 3, 0, 0, 0, 1};
    int dn_seq[6]   = '{0, 0, 3, 3, 3, 2};
    int rs_seq[3]   = '{1, 1, 2};
    int c_seq[4]    = '{7, 7, 7, 0};
    int c;
    int en;

    if_a.e = 1'b0; if_a.mode = 2'b00; if_a.sel = '0; if_a.start = 1'b0;
    if_b.e = 1'b0; if_b.mode = 2'b00; if_b.sel = '0; if_b.start = 1'b0;
    if_c.e = 1'b0; if_c.mode = 2'b00; if_c.sel = '0; if_c.start = 1'b0;

    // reset, direct decode, freeze
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int s = 0; s < 4; s++) tbl.push_back(mk(0, 0, 1, 0, s, 0, oh(s), s, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3, 0, 0, 3, 0, 0));
    // scan-up entry at 2 with wrap 3 -> 0
    tbl.push_back(mk(0, 0, 1, 1, 2, 0, oh(2), 2, 0, 0));
    for (int k = 0; k < 9; k++) tbl.push_back(mk(0, 0, 1, 1, 0, 0, oh(up_seq[k]), up_seq[k], 0, 0));
    // scan-down entry at 0 with wrap 0 -> 3
    tbl.push_back(mk(0, 0, 1, 2, 0, 0, oh(0), 0, 0, 0));
    for (int k = 0; k < 6; k++) tbl.push_back(mk(0, 0, 1, 2, 1, 0, oh(dn_seq[k]), dn_seq[k], 0, 0));
    // reset mid-scan, restart from sel
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, oh(1), 1, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, 1, 1, 1, 0, oh(rs_seq[k]), rs_seq[k], 0, 0));
    // active-low N=3
    tbl.push_back(mk(2, 1, 0, 0, 0, 0, 255, 0, 0, 0));
    tbl.push_back(mk(2, 0, 1, 0, 5, 0, 8'hDF, 5, 0, 0));
    tbl.push_back(mk(2, 0, 0, 0, 5, 0, 255, 5, 0, 0));
    tbl.push_back(mk(2, 0, 1, 1, 7, 0, ohl(7), 7, 0, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(2, 0, 1, 1, 0, 0, ohl(c_seq[k]), c_seq[k], 0, 0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // sweep with a second start during busy
    apply(mk(1, 0, 1, 3, 0, 0, 0, 0, 0, 0), "sw_idle");
    apply(mk(1, 0, 1, 3, 0, 1, oh(0), 0, 1, 0), "sw_start");
    for (int s = 1; s < 8; s++)
      apply(mk(1, 0, 1, 3, 0, (s == 2) ? 1 : 0, oh(s / 2), s / 2, 1, 0), $sformatf("sw_walk%0d", s));
    apply(mk(1, 0, 1, 3, 0, 0, 0, 3, 0, 1), "sw_done");
    apply(mk(1, 0, 1, 3, 0, 0, 0, 3, 0, 0), "sw_done_end");

    // sweep frozen for five cycles
    apply(mk(1, 0, 1, 3, 0, 1, oh(0), 0, 1, 0), "fz_start");
    c = 0;
    for (int s = 1; s < 14; s++) begin
      en = (s >= 3 && s <= 7) ? 0 : 1;
      if (en != 0) c++;
      if (c == 8)
        apply(mk(1, 0, en, 3, 0, 0, 0, 3, 0, 1), "fz_done");
      else
        apply(mk(1, 0, en, 3, 0, 0, (en != 0) ? oh(c / 2) : 0, c / 2, 1, 0), $sformatf("fz%0d", s));
    end
    apply(mk(1, 0, 1, 3, 0, 0, 0, 3, 0, 0), "fz_after");

    // abort by mode change, start ignored in direct
    apply(mk(1, 0, 1, 3, 0, 1, oh(0), 0, 1, 0), "ab_start");
    for (int s = 1; s < 5; s++) apply(mk(1, 0, 1, 3, 0, 0, oh(s / 2), s / 2, 1, 0), $sformatf("ab%0d", s));
    apply(mk(1, 0, 1, 0, 2, 0, oh(2), 2, 0, 0), "ab_abort");
    apply(mk(1, 0, 1, 0, 2, 1, oh(2), 2, 0, 0), "ab_nodone");

    // reset mid-sweep
    apply(mk(1, 0, 1, 3, 0, 0, 0, 2, 0, 0), "rs_idle");
    apply(mk(1, 0, 1, 3, 0, 1, oh(0), 0, 1, 0), "rs_start");
    for (int s = 1; s < 4; s++) apply(mk(1, 0, 1, 3, 0, 0, oh(s / 2), s / 2, 1, 0), $sformatf("rs%0d", s));
    apply(mk(1, 1, 1, 3, 0, 0, 0, 0, 0, 0), "rs_reset");
    apply(mk(1, 0, 1, 3, 0, 0, 0, 0, 0, 0), "rs_after");
    apply(mk(1, 0, 1, 3, 0, 0, 0, 0, 0, 0), "rs_after2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered successor to the 2-to-4 line decoder: decodes an N-bit select into a 2^N one-hot output with enable, and adds sequencing modes (continuous up/down scan and a one-shot sweep with busy/done handshake) for strobing rows, digit selects or chip enables. It sits between control logic and any bank of 2^N loads that must be selected one at a time. All outputs are registered.

## Interface
Parameters:
- N, 2, select width; output width is 2^N (N >= 1).
- DWELL, 4, cycles each line stays asserted in scan/sweep modes (DWELL >= 1).
- ACTIVE_LOW, 0, 1 inverts y (asserted line = 0, inactive = all ones).

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- e  input  1  enable; 0 forces y inactive and freezes all counters/state.
- mode  input  2  00 direct, 01 scan-up, 10 scan-down, 11 sweep.
- sel  input  N  line select (direct), start line (scan entry).
- start  input  1  sweep request, sampled only in mode 11 when idle.
- y  output  2^N  one-hot decoded lines (polarity per ACTIVE_LOW).
- idx  output  N  index of current line.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse at sweep completion.

## Operation
- Reset (rst=1 at a clk edge): y = inactive (0, or all ones if ACTIVE_LOW), idx = 0, busy = 0, done = 0, dwell counter = 0, mode tracker = 00. rst has priority over all inputs.
- e=0: next cycle y = inactive; idx, dwell counter, busy and mode tracker hold; done = 0. On e returning to 1, operation resumes from the held state (dwell count not restarted).
- Direct (00), e=1: idx <= sel, y <= onehot(sel) each cycle; dwell counter held at 0.
- Scan entry: when mode changes into 01 or 10 (registered previous mode differs), idx <= sel, dwell counter <= 0.
- Scan-up (01) / scan-down (10), e=1: y = onehot(idx); dwell counter increments each cycle; when it reaches DWELL-1 it clears and idx steps +1 / -1 modulo 2^N (2^N-1 -> 0 up, 0 -> 2^N-1 down). Runs continuously.
- Sweep (11): idle state y inactive, busy = 0. start=1 with e=1 and busy=0: busy <= 1, idx <= 0, dwell counter <= 0, y asserts line 0 next cycle. Steps up every DWELL cycles. After line 2^N-1 has been asserted DWELL cycles: y <= inactive, busy <= 0, done <= 1 for exactly one cycle, idx holds 2^N-1.
- start while busy=1: ignored. start in modes 00/01/10: ignored.
- Mode change away from 11 while busy: sweep aborts, busy <= 0, no done pulse; new mode applies that cycle.
- Any mode change resets the dwell counter to 0.
- Line count: exactly one bit of y asserted whenever e=1 and mode is 00/01/10 or busy=1; otherwise y inactive.

## Timing
- Latency: y and idx change one clk edge after the sampled inputs (direct: sel at edge k -> y at edge k+1).
- Scan period: each line asserted exactly DWELL cycles; full rotation 2^N * DWELL cycles.
- Sweep: start sampled at edge k -> line 0 at k+1; line i asserted cycles k+1+i*DWELL .. k+(i+1)*DWELL; done high and busy low from edge k+1+2^N*DWELL for one cycle.
- DWELL=1: idx changes every cycle; no stall cycles between lines.
- Freeze under e=0 stretches sweep/scan timing by exactly the number of e=0 cycles.
- rst mid-sweep: busy and done 0 next cycle, no done pulse.

## Test plan
- Reset/direct: N=2, rst 1 cycle, then e=1, mode=00, sel=0,1,2,3 -> y=0001,0010,0100,1000 each one cycle after sel; e=0 -> y=0000 next cycle.
- Scan-up wrap: N=2, DWELL=3, mode 00->01 with sel=2 -> idx 2,2,2,3,3,3,0,0,0,1...; scan-down from sel=0 -> 0 then 3 after 3 cycles.
- Sweep handshake: N=2, DWELL=2, mode=11, start pulse at edge k -> busy=1 at k+1, y walks 0001..1000 two cycles each, done=1 and busy=0 at k+9 for one cycle, y=0000; second start during busy ignored.
- Freeze and abort: mid-sweep e=0 for 5 cycles -> y=0000, idx held, done delayed 5 cycles; separate run: mode 11->00 mid-sweep -> busy=0, no done.
- ACTIVE_LOW=1, N=3: reset -> y=11111111; direct sel=5 -> y=11011111.
- Reset mid-scan: rst during mode 01 -> y inactive, idx=0, busy=0 next cycle, then scan restarts from sel.
